// File: rtl/ureg_txn_arbiter.sv
// Two-requester arbiter that sequences load/shift/capture transactions on an external shift register.
// Define ROUND_ROBIN_EN for round-robin arbitration; the default build uses fixed priority (requester 0 wins).
//
// state   | meaning
// IDLE    | waiting for a request; winner id/op/wdata latched on grant
// LOAD    | one-cycle parallel load of latched wdata into the register
// SHIFT   | SHIFT_LEN cycles of serial shifting with the winner's sin
// CAPTURE | register parallel output captured into rdata
// DONE    | done pulse scheduled, grant dropped, pointer updated
module ureg_txn_arbiter #(
  parameter int SHIFT_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] op0,
  input  logic [1:0] op1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  input  logic       sin0,
  input  logic       sin1,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic [7:0] rdata,
  output logic       sout,
  output logic       busy,
  output logic       reg_enable,
  output logic       reg_load,
  output logic       reg_serial_in,
  output logic [1:0] reg_mode,
  output logic [7:0] reg_parallel_in,
  input  logic       reg_serial_out,
  input  logic [7:0] reg_parallel_out
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_SHIFT   = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [1:0] OP_SIPO = 2'b01;
  localparam logic [3:0] CNT_LAST = 4'(SHIFT_LEN - 1);

  logic [2:0] r_state;
  logic [3:0] r_cnt;
  logic       r_id;
  logic [1:0] r_op;
  logic [7:0] r_wdata;
  logic [1:0] r_gnt;
  logic [1:0] r_done;
  logic [1:0] r_mode;
  logic [7:0] r_rdata;

  logic       w_win_id;
  logic [1:0] w_win_op;
  logic [7:0] w_win_wdata;
  logic       w_sin;
  logic       w_in_load;
  logic       w_in_shift;

`ifdef ROUND_ROBIN_EN
  // r_ptr names the requester that wins when both request at once.
  logic r_ptr;

  always_comb begin
    w_win_id = 1'b0;
    if (req == 2'b11) begin
      w_win_id = r_ptr;
    end else if (req == 2'b10) begin
      w_win_id = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_ptr <= ~r_id;
    end
  end
`else
  assign w_win_id = ~req[0];
`endif

  always_comb begin
    w_win_op    = op0;
    w_win_wdata = wdata0;
    if (w_win_id) begin
      w_win_op    = op1;
      w_win_wdata = wdata1;
    end
  end

  assign w_sin      = r_id ? sin1 : sin0;
  assign w_in_load  = (r_state == S_LOAD);
  assign w_in_shift = (r_state == S_SHIFT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_id    <= 1'b0;
      r_op    <= 2'b00;
      r_wdata <= 8'h00;
      r_gnt   <= 2'b00;
      r_done  <= 2'b00;
      r_mode  <= 2'b00;
      r_rdata <= 8'h00;
    end else begin
      r_done <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_id    <= w_win_id;
            r_op    <= w_win_op;
            r_wdata <= w_win_wdata;
            r_mode  <= w_win_op;
            r_gnt   <= w_win_id ? 2'b10 : 2'b01;
            r_cnt   <= 4'd0;
            r_state <= w_win_op[1] ? S_LOAD : S_SHIFT;
          end
        end
        S_LOAD: begin
          r_cnt   <= 4'd0;
          r_state <= r_op[0] ? S_CAPTURE : S_SHIFT;
        end
        S_SHIFT: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= 4'd0;
            r_state <= (r_op == OP_SIPO) ? S_CAPTURE : S_DONE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_CAPTURE: begin
          r_rdata <= reg_parallel_out;
          r_state <= S_DONE;
        end
        S_DONE: begin
          // done is registered, so it lands in the IDLE cycle that follows
          r_done  <= r_gnt;
          r_gnt   <= 2'b00;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt             = r_gnt;
  assign done            = r_done;
  assign rdata           = r_rdata;
  assign busy            = (r_state != S_IDLE);
  assign reg_enable      = w_in_load | w_in_shift;
  assign reg_load        = w_in_load;
  assign reg_serial_in   = w_in_shift & w_sin;
  assign reg_mode        = r_mode;
  assign reg_parallel_in = w_in_load ? r_wdata : 8'h00;
  assign sout            = w_in_shift & reg_serial_out;

endmodule

// File: tb/tb_ureg_txn_arbiter.sv
// Self-checking bench for ureg_txn_arbiter: vector table, hand corner sequences, randomized transactions.
// Hosts a behavioural 8-bit shift register on the reg_* port and a transaction-level reference model.
module tb_ureg_txn_arbiter;

  localparam int L = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] op0 = 2'b00;
  logic [1:0] op1 = 2'b00;
  logic [7:0] wdata0 = 8'h00;
  logic [7:0] wdata1 = 8'h00;
  logic       sin0 = 1'b0;
  logic       sin1 = 1'b0;
  logic [1:0] gnt;
  logic [1:0] done;
  logic [7:0] rdata;
  logic       sout;
  logic       busy;
  logic       reg_enable;
  logic       reg_load;
  logic       reg_serial_in;
  logic [1:0] reg_mode;
  logic [7:0] reg_parallel_in;
  logic       reg_serial_out;
  logic [7:0] reg_parallel_out;

  ureg_txn_arbiter #(.SHIFT_LEN(L)) dut (
    .clk(clk), .rst(rst), .req(req), .op0(op0), .op1(op1),
    .wdata0(wdata0), .wdata1(wdata1), .sin0(sin0), .sin1(sin1),
    .gnt(gnt), .done(done), .rdata(rdata), .sout(sout), .busy(busy),
    .reg_enable(reg_enable), .reg_load(reg_load), .reg_serial_in(reg_serial_in),
    .reg_mode(reg_mode), .reg_parallel_in(reg_parallel_in),
    .reg_serial_out(reg_serial_out), .reg_parallel_out(reg_parallel_out)
  );

  always #5 clk = ~clk;

  // External register: loads in parallel or shifts left, serial out is the MSB.
  logic [7:0] q = 8'h00;
  assign reg_serial_out   = q[7];
  assign reg_parallel_out = q;
  always @(posedge clk) begin
    if (reg_enable) q <= reg_load ? reg_parallel_in : {q[6:0], reg_serial_in};
  end

  int checks = 0;
  int failures = 0;

  logic [7:0] m_reg   = 8'h00;
  logic [7:0] m_rdata = 8'h00;
  logic       m_ptr   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [26:0] obs();
    return {gnt, done, busy, reg_enable, reg_load, reg_serial_in, reg_mode, sout, rdata, reg_parallel_in};
  endfunction

  // Called at a negedge with the DUT idle; that cycle is T. Checks cycles T+1 .. T+latency.
  task automatic run_txn(input logic [1:0] rq, input logic [1:0] o0, input logic [1:0] o1,
                         input logic [7:0] w0, input logic [7:0] w1, input logic [15:0] sp,
                         input bit hold, input int exp_id, input int exp_lat, input string tag);
    int id, d, s0, capk;
    bit hl, sh, cp, in_load, in_shift;
    logic [1:0] op, gm;
    logic [7:0] wd, r, erd;
    logic esin, esout, sbit;
    logic [26:0] act, e;
    if (exp_id >= 0) id = exp_id;
    else if (rq == 2'b01) id = 0;
    else if (rq == 2'b10) id = 1;
    else begin
`ifdef ROUND_ROBIN_EN
      id = int'(m_ptr);
`else
      id = 0;
`endif
    end
    op = (id == 1) ? o1 : o0;
    wd = (id == 1) ? w1 : w0;
    gm = (id == 1) ? 2'b10 : 2'b01;
    hl = op[1];
    sh = (op != 2'b11);
    cp = op[0];
    case (op)
      2'b11:        d = 4;
      2'b01, 2'b10: d = L + 3;
      default:      d = L + 2;
    endcase
    if (exp_lat >= 0) d = exp_lat;
    s0   = hl ? 2 : 1;
    capk = s0 + (sh ? L : 0);
    r    = hl ? wd : m_reg;
    req = rq; op0 = o0; op1 = o1; wdata0 = w0; wdata1 = w1;
    for (int k = 1; k <= d; k++) begin
      @(negedge clk);
      in_load  = hl && (k == 1);
      in_shift = sh && (k >= s0) && (k < s0 + L);
      sbit = in_shift ? sp[4'(k - s0)] : 1'($urandom);
      if (id == 1) begin sin1 = sbit; sin0 = 1'($urandom); end
      else         begin sin0 = sbit; sin1 = 1'($urandom); end
      if ((!hold && k == 1) || (hold && k == d - 1)) req = 2'b00;
      if (k >= 2) begin
        op0 = 2'($urandom); op1 = 2'($urandom);
        wdata0 = 8'($urandom); wdata1 = 8'($urandom);
      end
      #1;
      esin  = in_shift ? sbit : 1'b0;
      esout = in_shift ? r[7] : 1'b0;
      erd   = (cp && k > capk) ? r : m_rdata;
      e = {((k < d) ? gm : 2'b00), ((k == d) ? gm : 2'b00), (k < d),
           (in_load | in_shift), in_load, esin, op, esout, erd, (in_load ? wd : 8'h00)};
      act = obs();
      if (!in_load) act[7:0] = 8'h00;
      chk($sformatf("%s_cyc%0d", tag, k), 32'(act), 32'(e));
      if (in_shift) r = {r[6:0], sbit};
    end
    m_reg = r;
    if (cp) m_rdata = r;
`ifdef ROUND_ROBIN_EN
    m_ptr = (id == 0);
`endif
  endtask

  typedef struct {
    logic [1:0]  rq;
    logic [1:0]  o0;
    logic [1:0]  o1;
    logic [7:0]  w0;
    logic [7:0]  w1;
    logic [15:0] sp;
    bit          hold;
    int          exp_id;
    int          exp_lat;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [1:0] g[3];
    logic [1:0] prev;
    int n;
    logic [15:0] sp;

    tbl[0] = '{2'b01, 2'b11, 2'b00, 8'hEF, 8'h00, 16'h0000, 1'b0, 0, 4};
    tbl[1] = '{2'b10, 2'b00, 2'b01, 8'h00, 8'h00, 16'h004D, 1'b0, 1, L + 3};
    tbl[2] = '{2'b01, 2'b10, 2'b00, 8'hDB, 8'h00, 16'h0000, 1'b1, 0, L + 3};
    tbl[3] = '{2'b10, 2'b11, 2'b00, 8'h55, 8'h00, 16'hA5C3, 1'b1, 1, L + 2};
    tbl[4] = '{2'b10, 2'b00, 2'b11, 8'h00, 8'h3C, 16'h0000, 1'b0, 1, 4};
    tbl[5] = '{2'b01, 2'b01, 2'b00, 8'h00, 8'h00, 16'h00F0, 1'b0, 0, L + 3};
    tbl[3].o1 = 2'b00;

    #2 rst = 1'b0;
    #1 chk("reset_outputs", 32'(obs()), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 32'({gnt, done, busy}), 32'h0);

    // Continuous simultaneous requests, PIPO on both sides.
    op0 = 2'b11; op1 = 2'b11; wdata0 = 8'h11; wdata1 = 8'h22; req = 2'b11;
    n = 0; prev = 2'b00;
    for (int c = 0; c < 40 && n < 3; c++) begin
      @(negedge clk);
      #1;
      if (gnt != 2'b00 && prev == 2'b00) begin
        g[n] = gnt;
        n++;
        if (n == 3) req = 2'b00;
      end
      prev = gnt;
    end
    chk("arb_grant_count", 32'(n), 32'd3);
    if (n == 3) begin
`ifdef ROUND_ROBIN_EN
      chk("arb_grant0", 32'(g[0]), 32'h1);
      chk("arb_grant1", 32'(g[1]), 32'h2);
      chk("arb_grant2", 32'(g[2]), 32'h1);
      m_ptr = 1'b1;
`else
      chk("arb_grant0", 32'(g[0]), 32'h1);
      chk("arb_grant1", 32'(g[1]), 32'h1);
      chk("arb_grant2", 32'(g[2]), 32'h1);
`endif
    end
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (!busy) begin n = 1; break; end
    end
    chk("arb_drain_idle", 32'(n), 32'd1);
    m_reg = 8'h11;
    m_rdata = 8'h11;

    for (int i = 0; i < 6; i++) begin
      run_txn(tbl[i].rq, tbl[i].o0, tbl[i].o1, tbl[i].w0, tbl[i].w1, tbl[i].sp,
              tbl[i].hold, tbl[i].exp_id, tbl[i].exp_lat, $sformatf("vec%0d", i));
    end

    // Abort a SISO transaction with reset during the counter=3 shift cycle.
    sp = 16'h0007;
    req = 2'b01; op0 = 2'b00; sin1 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) req = 2'b00;
      sin0 = (k <= 3) ? sp[4'(k - 1)] : 1'b1;
    end
    #1 rst = 1'b0;
    #1 chk("abort_outputs_zero", 32'(obs()), 32'h0);
    m_reg = {m_reg[4:0], 3'b111};
    m_rdata = 8'h00;
    m_ptr = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1 chk($sformatf("abort_held_%0d", c), 32'({gnt, done, busy}), 32'h0);
    end
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1 chk($sformatf("abort_no_done_%0d", c), 32'({gnt, done, busy}), 32'h0);
    end
    run_txn(2'b01, 2'b00, 2'b00, 8'h00, 8'h00, 16'h6A93, 1'b0, 0, L + 2, "restart_siso");
    run_txn(2'b10, 2'b00, 2'b10, 8'h00, 8'hC7, 16'h0F0F, 1'b0, 1, L + 3, "restart_piso");

    for (int i = 0; i < 40; i++) begin
      run_txn(2'($urandom_range(1, 3)), 2'($urandom), 2'($urandom), 8'($urandom), 8'($urandom),
              16'($urandom), 1'($urandom), -1, -1, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
